// File: rtl/tx_bram_writer_pkg.sv
// Shared types and constants for the TX BRAM writer: FSM state encoding and
// the AXIS / BRAM data widths.
package tx_bram_writer_pkg;

    localparam int AXIS_DATA_W      = 32;
    localparam int BRAM_DATA_W      = 64;
    localparam int DEF_BRAM_ADDR_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT_KICK,
        ST_START,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/tx_bram_writer_if.sv
// AXI-Stream input from the host DMA and the BRAM write port toward dot11_tx.
// The slave modport is the writer; the master modport is the DMA/BRAM side.
interface tx_bram_writer_if
    import tx_bram_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_BRAM_ADDR_W
);

    logic [AXIS_DATA_W-1:0] s_axis_tdata;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic                   s_axis_tlast;
    logic                   bram_wen;
    logic [ADDR_W-1:0]      bram_waddr;
    logic [BRAM_DATA_W-1:0] bram_dout;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready, bram_wen, bram_waddr, bram_dout
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready, bram_wen, bram_waddr, bram_dout
    );

endinterface

// File: rtl/tx_word_packer.sv
// Assembles consecutive 32-bit beats into 64-bit words (first beat = low half).
// word_valid pulses combinationally on the beat that completes a word.
module tx_word_packer
    import tx_bram_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic                   in_last,
    input  logic                   flush,
    output logic                   word_valid,
    output logic [BRAM_DATA_W-1:0] word
);

    logic                   phase;
    logic [AXIS_DATA_W-1:0] low;

    // A word completes on a high-half beat, or early on a low-half tlast (zero-padded)
    assign word_valid = in_valid && (phase || in_last);
    assign word       = phase ? {in_data, low} : {{AXIS_DATA_W{1'b0}}, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            low   <= '0;
        end else if (flush) begin
            phase <= 1'b0;
        end else if (in_valid) begin
            if (word_valid) begin
                phase <= 1'b0;
            end else begin
                phase <= 1'b1;
                low   <= in_data;
            end
        end
    end

endmodule

// File: rtl/tx_bram_writer.sv
// Fills the 64-bit TX BRAM from a 32-bit AXIS stream, then starts dot11_tx and
// locks the BRAM until done. Optional watchdog: TX_BRAM_WRITER_WATCHDOG_EN.
module tx_bram_writer
    import tx_bram_writer_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_W,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                     clk,
    input  logic                     phy_tx_arest,
    tx_bram_writer_if.slave          bus,
    input  logic                     tx_auto_start,
    input  logic                     tx_kick,
    output logic                     phy_tx_start,
    input  logic                     phy_tx_done,
    output logic [BRAM_ADDR_WIDTH:0] pkt_num_dw,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int W = BRAM_ADDR_WIDTH;

    state_t                 state;
    state_t                 next_state;
    logic                   tready_q;
    logic                   beat;
    logic                   full;
    logic                   pack_valid;
    logic                   pack_flush;
    logic                   wr;
    logic [BRAM_DATA_W-1:0] word;
    logic [W:0]             word_cnt;
    logic [W:0]             base_cnt;
    logic [W:0]             next_cnt;
    logic                   wd_expire;
    logic                   wen_q;
    logic [W-1:0]           waddr_q;
    logic [BRAM_DATA_W-1:0] dout_q;

    assign beat       = bus.s_axis_tvalid && tready_q;
    // Counter reads as zero in IDLE so a new packet always starts at address 0
    assign base_cnt   = (state == ST_IDLE) ? '0 : word_cnt;
    assign full       = base_cnt[W];
    assign pack_valid = beat && !full;
    assign pack_flush = !((state == ST_IDLE) || (state == ST_FILL));
    assign next_cnt   = base_cnt + {{W{1'b0}}, wr};

    assign bus.s_axis_tready = tready_q;
    assign bus.bram_wen      = wen_q;
    assign bus.bram_waddr    = waddr_q;
    assign bus.bram_dout     = dout_q;
    assign busy              = (state != ST_IDLE);

    tx_word_packer u_packer (
        .clk        (clk),
        .rst        (phy_tx_arest),
        .in_valid   (pack_valid),
        .in_data    (bus.s_axis_tdata),
        .in_last    (bus.s_axis_tlast),
        .flush      (pack_flush),
        .word_valid (wr),
        .word       (word)
    );

`ifdef TX_BRAM_WRITER_WATCHDOG_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            wd_cnt <= '0;
        end else if (state != ST_WAIT_DONE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign wd_expire = (state == ST_WAIT_DONE) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            timeout <= 1'b0;
        end else if ((state == ST_IDLE) && beat) begin
            timeout <= 1'b0;
        end else if (wd_expire && !phy_tx_done) begin
            timeout <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (beat) begin
                    if (bus.s_axis_tlast) begin
                        next_state = tx_auto_start ? ST_START : ST_WAIT_KICK;
                    end else begin
                        next_state = ST_FILL;
                    end
                end
            end
            ST_WAIT_KICK: if (tx_kick) next_state = ST_START;
            ST_START:     next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (phy_tx_done || wd_expire) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            tready_q     <= 1'b1;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            dout_q       <= '0;
            word_cnt     <= '0;
            pkt_num_dw   <= '0;
            overflow     <= 1'b0;
            phy_tx_start <= 1'b0;
        end else begin
            tready_q     <= (next_state == ST_IDLE) || (next_state == ST_FILL);
            // Registered one cycle behind START so the pulse follows the final write
            phy_tx_start <= (state == ST_START);
            wen_q        <= wr;
            if (wr) begin
                waddr_q <= base_cnt[W-1:0];
                dout_q  <= word;
            end
            if (beat) begin
                word_cnt <= next_cnt;
            end
            if (beat && bus.s_axis_tlast) begin
                pkt_num_dw <= next_cnt;
            end
            if ((state == ST_IDLE) && beat) begin
                overflow <= 1'b0;
            end else if (beat && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_bram_writer.sv
// Testbench for tx_bram_writer: table-driven packets, directed corner sequences
// and random packets checked against a packet-level reference model.
module tb_tx_bram_writer;

    localparam int W     = 3;
    localparam int DEPTH = 8;
    localparam int TO    = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_auto_start;
    logic         tx_kick;
    logic         phy_tx_start;
    logic         phy_tx_done;
    logic [W:0]   pkt_num_dw;
    logic         busy;
    logic         overflow;
    logic         timeout;

    tx_bram_writer_if #(.ADDR_W(W)) bus ();

    tx_bram_writer #(.BRAM_ADDR_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .phy_tx_arest  (rst),
        .bus           (bus.slave),
        .tx_auto_start (tx_auto_start),
        .tx_kick       (tx_kick),
        .phy_tx_start  (phy_tx_start),
        .phy_tx_done   (phy_tx_done),
        .pkt_num_dw    (pkt_num_dw),
        .busy          (busy),
        .overflow      (overflow),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write / start log collected by the monitor
    logic [W-1:0] wr_addr[$];
    logic [63:0]  wr_data[$];
    int           wr_cyc[$];
    int           start_cnt = 0;
    int           start_cyc = 0;

    always @(negedge clk) begin
        if (bus.bram_wen) begin
            wr_addr.push_back(bus.bram_waddr);
            wr_data.push_back(bus.bram_dout);
            wr_cyc.push_back(cyc);
        end
        if (phy_tx_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    logic [31:0] pkt[$];
    int          w0;
    int          s0;

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        bit          auto_start;
        int          exp_num;
        bit          exp_ovf;
        logic [63:0] exp_w0;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last, output bit acc);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        acc = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk); #1;
            if (acc) break;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic drive_packet(input bit done_in_start);
        int acc_cnt;
        bit acc;
        acc_cnt = 0;
        w0 = wr_addr.size();
        s0 = start_cnt;
        for (int i = 0; i < pkt.size(); i++) begin
            send_beat(pkt[i], (i == pkt.size() - 1), acc);
            if (!acc) begin
                chk("beat_accept_bound", 64'd0, 64'd1);
                return;
            end
            acc_cnt++;
        end
        // This cycle is START when auto start is set; done here must be ignored
        phy_tx_done = done_in_start;
        @(negedge clk);
        chk("tready_after_tlast", bus.s_axis_tready, 64'd0);
        chk("beats_accepted", acc_cnt, pkt.size());
        @(posedge clk); #1;
        phy_tx_done = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (phy_tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Reference: beats pair into words low-first, odd tail zero-padded, capped at DEPTH
    task automatic check_writes();
        int          n;
        int          nw;
        logic [63:0] exp;
        logic [31:0] hi;
        n  = pkt.size();
        nw = (n + 1) / 2;
        if (nw > DEPTH) nw = DEPTH;
        chk("num_writes", wr_addr.size() - w0, nw);
        for (int i = 0; i < nw && (w0 + i) < wr_addr.size(); i++) begin
            hi  = (2 * i + 1 < n) ? pkt[2 * i + 1] : 32'h0;
            exp = {hi, pkt[2 * i]};
            chk($sformatf("waddr[%0d]", i), wr_addr[w0 + i], i);
            chk($sformatf("wdata[%0d]", i), wr_data[w0 + i], exp);
        end
        chk("pkt_num_dw", pkt_num_dw, nw);
        chk("overflow", overflow, (n > 2 * DEPTH) ? 64'd1 : 64'd0);
    endtask

    task automatic finish_tx();
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("busy_before_done", {busy, bus.s_axis_tready}, 64'd2);
        @(posedge clk); #1;
        phy_tx_done = 1'b1;
        @(posedge clk); #1;
        phy_tx_done = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {busy, bus.s_axis_tready}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_packet(input bit auto_start, input bit done_in_start);
        bit ok;
        tx_auto_start = auto_start;
        drive_packet(done_in_start);
        if (!auto_start) begin
            repeat (3) begin @(posedge clk); #1; end
            chk("no_start_before_kick", start_cnt - s0, 64'd0);
            tx_kick = 1'b1;
            @(posedge clk); #1;
            tx_kick = 1'b0;
        end
        wait_start(ok);
        chk("start_seen", ok, 64'd1);
        check_writes();
        if (auto_start && pkt.size() <= 2 * DEPTH && wr_cyc.size() > w0)
            chk("start_latency", start_cyc - wr_cyc[wr_cyc.size() - 1], 64'd1);
        finish_tx();
        chk("start_pulses", start_cnt - s0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"}, bus.bram_dout, 64'd0);
        chk({tag, "_ctrl"}, {bus.bram_wen, bus.bram_waddr, phy_tx_start, pkt_num_dw,
                             busy, overflow, timeout}, 64'd0);
        chk({tag, "_tready"}, bus.s_axis_tready, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit bad;
        int cnt;

        vecs[0] = '{4,  32'h11111111, 32'h11111111, 1'b1, 2, 1'b0, 64'h2222222211111111};
        vecs[1] = '{1,  32'hDEADBEEF, 32'h00000000, 1'b1, 1, 1'b0, 64'h00000000DEADBEEF};
        vecs[2] = '{20, 32'h00000001, 32'h00000001, 1'b1, 8, 1'b1, 64'h0000000200000001};
        vecs[3] = '{3,  32'hA0000000, 32'h00000001, 1'b0, 2, 1'b0, 64'hA0000001A0000000};
        vecs[4] = '{16, 32'h00000100, 32'h00000100, 1'b1, 8, 1'b0, 64'h0000020000000100};
        vecs[5] = '{17, 32'hCAFE0000, 32'h00000001, 1'b0, 8, 1'b1, 64'hCAFE0001CAFE0000};

        rst               = 1'b1;
        tx_auto_start     = 1'b1;
        tx_kick           = 1'b0;
        phy_tx_done       = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            pkt.delete();
            for (int i = 0; i < vecs[v].n; i++) pkt.push_back(vecs[v].base + vecs[v].step * i);
            run_packet(vecs[v].auto_start, 1'b0);
            if (wr_data.size() > w0) chk($sformatf("tbl%0d_w0", v), wr_data[w0], vecs[v].exp_w0);
            else chk($sformatf("tbl%0d_w0_present", v), 64'd0, 64'd1);
            chk($sformatf("tbl%0d_num", v), pkt_num_dw, vecs[v].exp_num);
            chk($sformatf("tbl%0d_ovf", v), overflow, vecs[v].exp_ovf);
        end

        // Manual kick: stray kick in IDLE is dropped, then 100 idle cycles in WAIT_KICK
        tx_auto_start = 1'b0;
        tx_kick = 1'b1;
        @(posedge clk); #1;
        tx_kick = 1'b0;
        pkt.delete();
        pkt.push_back(32'h0BADF00D);
        pkt.push_back(32'h12345678);
        drive_packet(1'b0);
        bad = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (phy_tx_start || bus.s_axis_tready || !busy) bad = 1'b1;
        end
        chk("kick_wait_held", bad, 64'd0);
        @(posedge clk); #1;
        tx_kick = 1'b1;
        @(posedge clk); #1;
        tx_kick = 1'b0;
        wait_start(ok);
        chk("kick_start_seen", ok, 64'd1);
        check_writes();
        bad = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.s_axis_tready) bad = 1'b1;
        end
        chk("kick_tready_locked", bad, 64'd0);
        @(posedge clk); #1;
        finish_tx();
        chk("kick_start_pulses", start_cnt - s0, 64'd1);

        // Done during START must be ignored
        pkt.delete();
        for (int i = 0; i < 4; i++) pkt.push_back($urandom);
        tx_auto_start = 1'b1;
        drive_packet(1'b1);
        repeat (4) @(negedge clk);
        chk("done_in_start_ignored", {busy, bus.s_axis_tready}, 64'd2);
        @(posedge clk); #1;
        finish_tx();
        chk("done_in_start_pulses", start_cnt - s0, 64'd1);

        // Reset mid-FILL, then a fresh packet starts at address 0
        pkt.delete();
        for (int i = 0; i < 3; i++) begin
            send_beat(32'hF0000000 + i, 1'b0, ok);
        end
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) pkt.push_back(32'h50000000 + i);
        run_packet(1'b1, 1'b0);

`ifdef TX_BRAM_WRITER_WATCHDOG_EN
        pkt.delete();
        pkt.push_back(32'h77777777);
        pkt.push_back(32'h88888888);
        tx_auto_start = 1'b1;
        drive_packet(1'b0);
        wait_start(ok);
        chk("wd_start_seen", ok, 64'd1);
        cnt = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        chk("wd_wait_cycles", cnt, TO);
        chk("wd_timeout_set", timeout, 64'd1);
        @(posedge clk); #1;
        pkt.delete();
        pkt.push_back(32'h99999999);
        run_packet(1'b1, 1'b0);
        chk("wd_timeout_cleared", timeout, 64'd0);
`else
        pkt.delete();
        pkt.push_back(32'h77777777);
        pkt.push_back(32'h88888888);
        tx_auto_start = 1'b1;
        drive_packet(1'b0);
        wait_start(ok);
        chk("nowd_start_seen", ok, 64'd1);
        cnt = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (busy && !timeout) cnt++;
        end
        chk("nowd_waits_forever", cnt, 64'd200);
        @(posedge clk); #1;
        finish_tx();
`endif

        // Random packets against the reference model
        for (int r = 0; r < 12; r++) begin
            bit a;
            pkt.delete();
            for (int i = 0; i < $urandom_range(1, 20); i++) pkt.push_back($urandom);
            a = 1'($urandom_range(0, 1));
            run_packet(a, a ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tx_bram_writer.md
# tx_bram_writer

Fills the 64-bit TX packet BRAM that `dot11_tx` reads, from a 32-bit AXI-Stream fed by the host DMA. After a packet has been written it issues `phy_tx_start` and then locks the BRAM until the transmitter reports `phy_tx_done`. It sits beside `openofdm_tx` on the same clock and owns the BRAM write port; `dot11_tx` owns the read port.

## Interface
Parameters:
- `BRAM_ADDR_WIDTH`, default 10 — BRAM depth is 2^W 64-bit words; matches `bram_addr`.
- `TIMEOUT_CYCLES`, default 65535 — watchdog limit; used only when the watchdog is compiled in.

Ports:
- `clk` in 1 — the single clock, shared with `dot11_tx`.
- `phy_tx_arest` in 1 — reset, asynchronous, active-high.
- `s_axis_tdata` in 32 — packet data; the first beat of a packet maps to the low half of BRAM word 0.
- `s_axis_tvalid` in 1; `s_axis_tready` out 1; `s_axis_tlast` in 1 — standard AXIS handshake.
- `bram_wen` out 1 — write enable.
- `bram_waddr` out W — write address.
- `bram_dout` out 64 — write data.
- `tx_auto_start` in 1 — 1: start transmission immediately after the packet is written; 0: wait for `tx_kick`.
- `tx_kick` in 1 — manual start request, sampled only in WAIT_KICK.
- `phy_tx_start` out 1 — one-cycle start pulse to `dot11_tx`.
- `phy_tx_done` in 1 — transmission finished (level or pulse).
- `pkt_num_dw` out W+1 — number of 64-bit words written for the last packet.
- `busy` out 1 — high in any state other than IDLE.
- `overflow` out 1 — sticky: packet exceeded BRAM depth.
- `timeout` out 1 — sticky: watchdog fired (tied 0 when the watchdog is compiled out).

## Operation
- States: IDLE, FILL, WAIT_KICK, START, WAIT_DONE.
- **IDLE:** `tready`=1. On the first accepted beat:
  - go to FILL;
  - clear `overflow`, `timeout` and the word counter;
  - load the beat into the low half of the pack register.
- **FILL:** `tready`=1. Beats alternate low half / high half. Accepting a high-half beat issues a write of {high, low} at the current address, then the address increments.
- **tlast handling:**
  - tlast on a low-half beat writes {32'h0, low}.
  - `pkt_num_dw` latches the total word count, so a single-beat packet gives 1.
  - Next state is START if `tx_auto_start`=1, otherwise WAIT_KICK.
- **Overflow:** once word 2^W−1 has been written, further beats are accepted and discarded (`tready` stays 1 so the DMA drains) and `overflow` sets. The address never wraps back to 0. tlast still ends the packet normally.
- **WAIT_KICK:** `tready`=0; `tx_kick`=1 moves to START.
- **START:** `phy_tx_start`=1 for exactly one cycle, then WAIT_DONE.
- **WAIT_DONE:** `tready`=0; `phy_tx_done`=1 returns to IDLE. The BRAM is never written outside IDLE/FILL.
- **Reset mid-packet:** everything returns to IDLE immediately and the partial packet is abandoned.
- **Reset values:** all outputs 0 except `s_axis_tready`, which is 1 (IDLE).

## Timing
- `bram_wen`, `bram_waddr` and `bram_dout` are registered: the write appears the cycle after the completing beat is accepted.
- The state change on tlast takes effect the same edge as the final write is registered. With auto start, `phy_tx_start` is asserted 1 cycle after that write.
- `tready` is registered from the state, so it drops the cycle after tlast is accepted. No beat is accepted in the tlast+1 cycle.
- `phy_tx_done` arriving in the same cycle as START is ignored; only WAIT_DONE samples it.
- `tx_kick` asserted outside WAIT_KICK is ignored and is not latched.
- Back-to-back packets: the minimum gap is tlast → START → WAIT_DONE → done → IDLE, with `tready` high again the cycle after `phy_tx_done`.

## Configuration
- `TX_BRAM_WRITER_WATCHDOG_EN` defined:
  - a counter runs in WAIT_DONE;
  - after `TIMEOUT_CYCLES` cycles without `phy_tx_done`, the block returns to IDLE and sets `timeout`;
  - the counter clears on every entry to WAIT_DONE.
- Not defined: there is no counter, `timeout` is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- Package `tx_bram_writer_pkg` holds:
  - the state enum;
  - the 32/64 data-width constants;
  - the `BRAM_ADDR_WIDTH` default.
- One sub-module, `tx_word_packer`: 32→64 half-word assembly. It has the pack register and phase bit, with `last`/`flush` handling, and emits a word-valid pulse.
- The FSM, address counter, status and watchdog live in the top module.

## Test plan
- **Even-length packet:** 4 beats `0x11111111`..`0x44444444`, tlast on beat 4, auto=1 → addr0=`0x2222222211111111`, addr1=`0x4444444433333333`, `pkt_num_dw`=2, one `phy_tx_start` pulse.
- **Odd-length / single-beat packet:** 1 beat `0xDEADBEEF` with tlast → addr0=`0x00000000DEADBEEF`, `pkt_num_dw`=1.
- **Manual kick:**
  - auto=0, 2-beat packet → state WAIT_KICK, no start pulse;
  - hold `tx_kick`=0 for 100 cycles, then pulse it → exactly one start pulse;
  - `tready` stays 0 until `phy_tx_done`.
- **Overflow:** with W=3, send 20 beats → 8 writes at addresses 0..7, `overflow`=1, all 20 beats accepted, `pkt_num_dw`=8.
- **Reset mid-FILL:** assert `phy_tx_arest` after beat 3 → all outputs 0 and `tready`=1 during reset. The next packet writes from address 0.
- **Watchdog:** with the macro defined and `TIMEOUT_CYCLES`=50, never assert `phy_tx_done` → IDLE after 50 cycles, `timeout`=1, and the next packet's first beat clears it.
